// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, loads the IF/ID register, inserts bubbles.
// Optional statistics counters are enabled with the FETCH_STATS_EN macro.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BOOT_WAIT = 4,
    parameter logic [15:0] NOP       = 16'h0800
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] instruction,
    input  logic        RamSlot,
    input  logic        stall_id,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] pc,
    output logic [15:0] if_id_inst,
    output logic [15:0] if_id_pc1,
    output logic        if_id_valid,
    output logic        fetch_busy
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stat_fetched,
    output logic [15:0] stat_bubbles,
    output logic [15:0] stat_stalls
`endif
);

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] BOOT_CNT   = BOOT_WAIT[7:0];
    localparam state_t     INIT_STATE = (BOOT_WAIT == 0) ? S_RUN : S_BOOT;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_pc;
    logic [15:0] r_inst;
    logic [15:0] r_pc1;
    logic        r_valid;

    state_t      w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] w_pc_nxt;
    logic [15:0] w_inst_nxt;
    logic [15:0] w_pc1_nxt;
    logic        w_valid_nxt;
    logic [15:0] w_pc_inc;
    logic        w_ev_fetch;
    logic        w_ev_bubble;
    logic        w_ev_stall;

    assign w_pc_inc = r_pc + 16'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= INIT_STATE;
            r_cnt   <= BOOT_CNT;
            r_pc    <= RESET_PC;
            r_inst  <= NOP;
            r_pc1   <= RESET_PC;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_pc1   <= w_pc1_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_pc1_nxt   = r_pc1;
        w_valid_nxt = r_valid;
        w_ev_fetch  = 1'b0;
        w_ev_bubble = 1'b0;
        w_ev_stall  = 1'b0;
        case (r_state)
            S_BOOT: begin
                // Leaving on the count-of-one edge makes BOOT last exactly BOOT_WAIT cycles.
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
                if (r_cnt <= 8'd1) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (branch_taken) begin
                    w_pc_nxt    = branch_target;
                    w_inst_nxt  = NOP;
                    w_pc1_nxt   = branch_target;
                    w_valid_nxt = 1'b0;
                    w_ev_bubble = 1'b1;
                end else if (stall_id) begin
                    w_ev_stall = 1'b1;
                end else if (RamSlot) begin
                    // Bus is busy with data: keep the address and refetch it next cycle.
                    w_inst_nxt  = NOP;
                    w_pc1_nxt   = r_pc;
                    w_valid_nxt = 1'b0;
                    w_ev_bubble = 1'b1;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_inst_nxt  = instruction;
                    w_pc1_nxt   = w_pc_inc;
                    w_valid_nxt = 1'b1;
                    w_ev_fetch  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign pc          = r_pc;
    assign if_id_inst  = r_inst;
    assign if_id_pc1   = r_pc1;
    assign if_id_valid = r_valid;
    assign fetch_busy  = (r_state == S_BOOT);

`ifdef FETCH_STATS_EN
    logic [15:0] r_stat_fetched;
    logic [15:0] r_stat_bubbles;
    logic [15:0] r_stat_stalls;

    // Counters saturate rather than wrap so long runs never report a small value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stat_fetched <= 16'd0;
            r_stat_bubbles <= 16'd0;
            r_stat_stalls  <= 16'd0;
        end else begin
            if (w_ev_fetch && (r_stat_fetched != 16'hFFFF)) begin
                r_stat_fetched <= r_stat_fetched + 16'd1;
            end
            if (w_ev_bubble && (r_stat_bubbles != 16'hFFFF)) begin
                r_stat_bubbles <= r_stat_bubbles + 16'd1;
            end
            if (w_ev_stall && (r_stat_stalls != 16'hFFFF)) begin
                r_stat_stalls <= r_stat_stalls + 16'd1;
            end
        end
    end

    assign stat_fetched = r_stat_fetched;
    assign stat_bubbles = r_stat_bubbles;
    assign stat_stalls  = r_stat_stalls;
`else
    logic w_unused_ev;
    assign w_unused_ev = w_ev_fetch ^ w_ev_bubble ^ w_ev_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, sequential fetch, bubbles, stalls,
// redirects, PC wrap and asynchronous reset.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] instruction;
  logic        RamSlot;
  logic        stall_id;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic        fetch_busy;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched;
  logic [15:0] stat_bubbles;
  logic [15:0] stat_stalls;
`endif

  int n_pass = 0;
  int n_total = 0;

  // {pc, if_id_inst, if_id_pc1, if_id_valid, fetch_busy}
  logic [49:0] obs;
  assign obs = {pc, if_id_inst, if_id_pc1, if_id_valid, fetch_busy};

  fetch_unit #(
    .RESET_PC (16'h0000),
    .BOOT_WAIT(4),
    .NOP      (16'h0800)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .instruction  (instruction),
    .RamSlot      (RamSlot),
    .stall_id     (stall_id),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .if_id_inst   (if_id_inst),
    .if_id_pc1    (if_id_pc1),
    .if_id_valid  (if_id_valid),
    .fetch_busy   (fetch_busy)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_bubbles (stat_bubbles),
    .stat_stalls  (stat_stalls)
`endif
  );

  // clock / reset block
  always #5 CLK = ~CLK;

  // memory model: two fixed words, everything else pc ^ 5A5A
  always_comb begin
    if (pc == 16'h0000)      instruction = 16'h6801;
    else if (pc == 16'h0001) instruction = 16'h6902;
    else                     instruction = pc ^ 16'h5A5A;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RamSlot       = 1'b0;
    stall_id      = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
  endtask

  task automatic test_reset();
    logic [49:0] exp;
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    exp = {16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b1};
    n_total++;
    if (obs !== exp) $display("FAIL reset: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  // Releases reset and walks the 4 BOOT cycles with a branch request held high.
  task automatic test_boot(input string tag);
    logic [49:0] exp;
    RST           = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = {16'h0000, 16'h0800, 16'h0000, 1'b0, (i < 3) ? 1'b1 : 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL %s cycle %0d: got %h expected %h", tag, i, obs, exp);
      else n_pass++;
    end
    clear_inputs();
  endtask

  task automatic test_seq_fetch();
    logic [15:0] exp_pc[5];
    logic [15:0] exp_inst[5];
    logic [49:0] exp;
    exp_pc   = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    exp_inst = '{16'h6801, 16'h6902, 16'h5A58, 16'h5A59, 16'h5A5E};
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {exp_pc[i], exp_inst[i], exp_pc[i], 1'b1, 1'b0};
      n_total++;
      if (obs !== exp) $display("FAIL seq_fetch %0d: got %h expected %h", i, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_ramslot();
    logic [49:0] exp;
    RamSlot = 1'b1;
    tick();
    exp = {16'h0005, 16'h0800, 16'h0005, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL ramslot_bubble: got %h expected %h", obs, exp);
    else n_pass++;
    RamSlot = 1'b0;
    tick();
    exp = {16'h0006, 16'h5A5F, 16'h0006, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL ramslot_refetch: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [49:0] exp;
    exp = {16'h0006, 16'h5A5F, 16'h0006, 1'b1, 1'b0};
    stall_id = 1'b1;
    RamSlot  = 1'b1;
    tick();
    n_total++;
    if (obs !== exp) $display("FAIL stall_with_ramslot: got %h expected %h", obs, exp);
    else n_pass++;
    RamSlot = 1'b0;
    tick();
    n_total++;
    if (obs !== exp) $display("FAIL stall_hold: got %h expected %h", obs, exp);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_redirect();
    logic [49:0] exp;
    branch_taken  = 1'b1;
    branch_target = 16'h4000;
    stall_id      = 1'b1;
    RamSlot       = 1'b1;
    tick();
    exp = {16'h4000, 16'h0800, 16'h4000, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL redirect_over_stall: got %h expected %h", obs, exp);
    else n_pass++;
    branch_taken = 1'b0;
    stall_id     = 1'b0;
    tick();
    n_total++;
    if (obs !== exp) $display("FAIL redirect_then_ramslot: got %h expected %h", obs, exp);
    else n_pass++;
    clear_inputs();
    tick();
    exp = {16'h4001, 16'h1A5A, 16'h4001, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL redirect_target_fetch: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [49:0] exp;
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    exp = {16'hFFFE, 16'h0800, 16'hFFFE, 1'b0, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL wrap_redirect: got %h expected %h", obs, exp);
    else n_pass++;
    clear_inputs();
    tick();
    exp = {16'hFFFF, 16'hA5A4, 16'hFFFF, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL wrap_pre: got %h expected %h", obs, exp);
    else n_pass++;
    tick();
    exp = {16'h0000, 16'hA5A5, 16'h0000, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL wrap_to_zero: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    logic [47:0] exp;
    // 9 fetches, 4 bubbles, 2 stall cycles since the first reset release
    exp = {16'd9, 16'd4, 16'd2};
    n_total++;
    if ({stat_fetched, stat_bubbles, stat_stalls} !== exp)
      $display("FAIL stats: got %h expected %h", {stat_fetched, stat_bubbles, stat_stalls}, exp);
    else n_pass++;
  endtask
`endif

  task automatic test_async_reset();
    logic [49:0] exp;
    tick();
    exp = {16'h0001, 16'h6801, 16'h0001, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL pre_reset_fetch: got %h expected %h", obs, exp);
    else n_pass++;
    #2;
    RST = 1'b1;
    #1;
    exp = {16'h0000, 16'h0800, 16'h0000, 1'b0, 1'b1};
    n_total++;
    if (obs !== exp) $display("FAIL async_reset: got %h expected %h", obs, exp);
    else n_pass++;
`ifdef FETCH_STATS_EN
    n_total++;
    if ({stat_fetched, stat_bubbles, stat_stalls} !== 48'd0)
      $display("FAIL stats_reset: got %h expected 0", {stat_fetched, stat_bubbles, stat_stalls});
    else n_pass++;
`endif
    tick();
    test_boot("reboot");
    tick();
    exp = {16'h0001, 16'h6801, 16'h0001, 1'b1, 1'b0};
    n_total++;
    if (obs !== exp) $display("FAIL reboot_fetch: got %h expected %h", obs, exp);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_boot("boot");
    test_seq_fetch();
    test_ramslot();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
